// File: rtl/expr_eval_pkg.sv
// Shared constants and types for the expression evaluator: ASCII codes,
// FSM state encoding and the character classes produced by char_class.
package expr_eval_pkg;

   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_MUL   = 8'h2A;
   localparam logic [7:0] CH_EQ    = 8'h3D;

   typedef enum logic [1:0] {
      EXPD = 2'd0,
      OPER = 2'd1,
      OPND = 2'd2,
      ERR  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CLS_DIG = 3'd0,
      CLS_ADD = 3'd1,
      CLS_SUB = 3'd2,
      CLS_MUL = 3'd3,
      CLS_EQ  = 3'd4,
      CLS_BAD = 3'd5
   } cls_t;

endpackage

// File: rtl/expr_eval_if.sv
// Character-in / result-out bundle of the expression evaluator.
// The slave side is the evaluator, the master side feeds characters.
interface expr_eval_if #(
   parameter int WIDTH = 16
);

   logic [7:0]       in;
   logic             in_valid;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             error;
   logic             busy;

   modport master (
      output in,
      output in_valid,
      input  result,
      input  result_valid,
      input  error,
      input  busy
   );

   modport slave (
      input  in,
      input  in_valid,
      output result,
      output result_valid,
      output error,
      output busy
   );

endinterface

// File: rtl/expr_eval_char_class.sv
// Combinational classifier: maps an ASCII byte to its token class and,
// for digits, the numeric value 0..9.
module char_class
   import expr_eval_pkg::*;
(
   input  logic [7:0] ch_i,
   output cls_t       cls_o,
   output logic [3:0] digit_o
);

   // The low nibble of '0'..'9' is the digit value itself.
   assign digit_o = ch_i[3:0];

   always_comb begin
      cls_o = CLS_BAD;
      if (ch_i >= CH_0 && ch_i <= CH_9) begin
         cls_o = CLS_DIG;
      end else if (ch_i == CH_PLUS) begin
         cls_o = CLS_ADD;
      end else if (ch_i == CH_MINUS) begin
         cls_o = CLS_SUB;
      end else if (ch_i == CH_MUL) begin
         cls_o = CLS_MUL;
      end else if (ch_i == CH_EQ) begin
         cls_o = CLS_EQ;
      end
   end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator of single-digit +,-,* expressions terminated by '='.
// Products are folded into term; sums are folded into acc with a pending sign.
module expr_eval
   import expr_eval_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   expr_eval_if.slave bus
);

   cls_t       cls;
   logic [3:0] digit;

   char_class u_char_class (
      .ch_i    (bus.in),
      .cls_o   (cls),
      .digit_o (digit)
   );

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] term_q, term_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             neg_q, neg_d;
   logic             mul_q, mul_d;
   logic             valid_q, valid_d;
   logic             error_q, error_d;

   logic [WIDTH-1:0] digitExt;
   logic [WIDTH-1:0] signedTerm;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] product;

   assign digitExt   = {{(WIDTH-4){1'b0}}, digit};
   assign signedTerm = neg_q ? ({WIDTH{1'b0}} - term_q) : term_q;
   assign sum        = acc_q + signedTerm;
   assign product    = term_q * digitExt;

   // Next-state logic; result_valid is a pulse so it defaults low every cycle,
   // while result and error hold until the next strobe.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      term_d   = term_q;
      neg_d    = neg_q;
      mul_d    = mul_q;
      result_d = result_q;
      error_d  = error_q;
      valid_d  = 1'b0;

      if (bus.in_valid) begin
         case (state_q)
            EXPD: begin
               case (cls)
                  CLS_DIG: begin
                     term_d  = digitExt;
                     neg_d   = 1'b0;
                     mul_d   = 1'b0;
                     state_d = OPER;
                  end
                  CLS_EQ: begin
                     result_d = '0;
                     valid_d  = 1'b1;
                     error_d  = 1'b1;
                  end
                  default: state_d = ERR;
               endcase
            end

            OPND: begin
               case (cls)
                  CLS_DIG: begin
                     term_d  = mul_q ? product : digitExt;
                     state_d = OPER;
                  end
                  CLS_EQ: begin
                     result_d = '0;
                     valid_d  = 1'b1;
                     error_d  = 1'b1;
                     acc_d    = '0;
                     term_d   = '0;
                     neg_d    = 1'b0;
                     mul_d    = 1'b0;
                     state_d  = EXPD;
                  end
                  default: state_d = ERR;
               endcase
            end

            OPER: begin
               case (cls)
                  CLS_ADD, CLS_SUB: begin
                     acc_d   = sum;
                     neg_d   = (cls == CLS_SUB);
                     mul_d   = 1'b0;
                     state_d = OPND;
                  end
                  CLS_MUL: begin
                     mul_d   = 1'b1;
                     state_d = OPND;
                  end
                  CLS_EQ: begin
                     result_d = sum;
                     valid_d  = 1'b1;
                     error_d  = 1'b0;
                     acc_d    = '0;
                     term_d   = '0;
                     neg_d    = 1'b0;
                     mul_d    = 1'b0;
                     state_d  = EXPD;
                  end
                  default: state_d = ERR;
               endcase
            end

            ERR: begin
               if (cls == CLS_EQ) begin
                  result_d = '0;
                  valid_d  = 1'b1;
                  error_d  = 1'b1;
                  acc_d    = '0;
                  term_d   = '0;
                  neg_d    = 1'b0;
                  mul_d    = 1'b0;
                  state_d  = EXPD;
               end
            end

            default: state_d = EXPD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EXPD;
         acc_q    <= '0;
         term_q   <= '0;
         neg_q    <= 1'b0;
         mul_q    <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         term_q   <= term_d;
         neg_q    <= neg_d;
         mul_q    <= mul_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
   assign bus.error        = error_q;
   assign bus.busy         = (state_q != EXPD);

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a 16-bit and an 8-bit instance share one
// character stream, and outputs are checked against hand-computed values.
module tb_expr_eval;

   logic       clk;
   logic       rst_n;
   logic [7:0] chIn;
   logic       vIn;

   int vectors     = 0;
   int miscompares = 0;

   expr_eval_if #(.WIDTH(16)) bus16 ();
   expr_eval_if #(.WIDTH(8))  bus8 ();

   assign bus16.in       = chIn;
   assign bus16.in_valid = vIn;
   assign bus8.in        = chIn;
   assign bus8.in_valid  = vIn;

   expr_eval #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16.slave)
   );

   expr_eval #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One character per call: driven on the falling edge, consumed on the next
   // rising edge, and in_valid dropped 1 time unit later.
   task automatic applyStimulus(input logic [7:0] c);
      @(negedge clk);
      chIn = c;
      vIn  = 1'b1;
      @(posedge clk);
      #1;
      vIn  = 1'b0;
   endtask

   task automatic applyString(input string s);
      for (int i = 0; i < s.len(); i++) begin
         applyStimulus(s[i]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] expResult,
                              input logic expValid, input logic expError,
                              input logic expBusy);
      vectors++;
      assert (bus16.result === expResult) else begin
         miscompares++;
         $error("[TB] FAIL %s result: got %h, expected %h", tag, bus16.result, expResult);
      end
      vectors++;
      assert (bus16.result_valid === expValid) else begin
         miscompares++;
         $error("[TB] FAIL %s result_valid: got %b, expected %b", tag, bus16.result_valid, expValid);
      end
      vectors++;
      assert (bus16.error === expError) else begin
         miscompares++;
         $error("[TB] FAIL %s error: got %b, expected %b", tag, bus16.error, expError);
      end
      vectors++;
      assert (bus16.busy === expBusy) else begin
         miscompares++;
         $error("[TB] FAIL %s busy: got %b, expected %b", tag, bus16.busy, expBusy);
      end
   endtask

   task automatic checkNarrow(input string tag, input logic [7:0] expResult,
                              input logic expValid, input logic expError);
      vectors++;
      assert (bus8.result === expResult) else begin
         miscompares++;
         $error("[TB] FAIL %s result8: got %h, expected %h", tag, bus8.result, expResult);
      end
      vectors++;
      assert (bus8.result_valid === expValid) else begin
         miscompares++;
         $error("[TB] FAIL %s result_valid8: got %b, expected %b", tag, bus8.result_valid, expValid);
      end
      vectors++;
      assert (bus8.error === expError) else begin
         miscompares++;
         $error("[TB] FAIL %s error8: got %b, expected %b", tag, bus8.error, expError);
      end
      vectors++;
      assert (bus8.busy === 1'b0) else begin
         miscompares++;
         $error("[TB] FAIL %s busy8: got %b, expected 0", tag, bus8.busy);
      end
   endtask

   string errCases [5] = '{"1++2=", "=", "12=", "1+=", "1&2="};
   string gapStr;

   initial begin
      chIn  = 8'h00;
      vIn   = 1'b0;
      rst_n = 1'b0;

      idle(2);
      checkOutput("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1+2*3 = 7, with a held result one cycle later
      applyString("1+2*3");
      checkOutput("mid_1+2*3", 16'h0000, 1'b0, 1'b0, 1'b1);
      applyStimulus("=");
      checkOutput("strobe_7", 16'd7, 1'b1, 1'b0, 1'b0);
      idle(1);
      checkOutput("hold_7", 16'd7, 1'b0, 1'b0, 1'b0);

      // 9-2*3*2 = -3, then "4=" with no idle cycle between expressions
      applyString("9-2*3*2=");
      checkOutput("strobe_neg3", 16'hFFFD, 1'b1, 1'b0, 1'b0);
      applyStimulus("4");
      checkOutput("b2b_digit", 16'hFFFD, 1'b0, 1'b0, 1'b1);
      applyStimulus("=");
      checkOutput("b2b_strobe_4", 16'd4, 1'b1, 1'b0, 1'b0);

      // Malformed sequences all end in an error strobe with result 0
      foreach (errCases[k]) begin
         idle(1);
         applyString(errCases[k]);
         checkOutput({"err_", errCases[k]}, 16'h0000, 1'b1, 1'b1, 1'b0);
      end
      idle(1);
      checkOutput("err_hold", 16'h0000, 1'b0, 1'b1, 1'b0);

      // 9^6 = 531441: 0x1BF1 mod 2^16, 0xF1 mod 2^8
      applyString("9*9*9*9*9*9=");
      checkOutput("pow_w16", 16'h1BF1, 1'b1, 1'b0, 1'b0);
      checkNarrow("pow_w8", 8'hF1, 1'b1, 1'b0);

      // 3+4 with two idle cycles after every character
      gapStr = "3+4=";
      for (int i = 0; i < gapStr.len(); i++) begin
         applyStimulus(gapStr[i]);
         if (gapStr[i] == "=") begin
            checkOutput("gap_strobe_7", 16'd7, 1'b1, 1'b0, 1'b0);
         end else begin
            checkOutput("gap_char", 16'h1BF1, 1'b0, 1'b0, 1'b1);
            idle(2);
            checkOutput("gap_idle", 16'h1BF1, 1'b0, 1'b0, 1'b1);
         end
      end

      // Reset in the middle of "1+2" discards it without a strobe
      applyString("1+2");
      checkOutput("pre_reset", 16'd7, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("in_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("post_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      applyString("4=");
      checkOutput("after_reset_4", 16'd4, 1'b1, 1'b0, 1'b0);
      idle(1);
      checkOutput("after_reset_hold", 16'd4, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
